// File: rtl/generic_arbiter_pkg.sv
// Shared types and helpers for the generic round-robin arbiter.
// The lock index is stored at a fixed maximum width so the struct is N-independent.
package generic_arbiter_pkg;

  localparam int unsigned LIDX_MAXW = 8;

  function automatic int unsigned idxw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                 lock_q;
    logic [LIDX_MAXW-1:0] lidx_q;
  } lock_state_t;

endpackage

// File: rtl/generic_arbiter_if.sv
// Requester-side and output-stream signals of the arbiter, bundled with modports.
interface generic_arbiter_if
  import generic_arbiter_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 8
) ();

  localparam int unsigned IW = idxw(N);

  logic            flush_i;
  logic [IW-1:0]   rr_i;
  logic [N-1:0]    req_i;
  logic [N-1:0]    lock_i;
  logic [N-1:0]    gnt_o;
  logic [N*DW-1:0] data_i;
  logic            req_o;
  logic [DW-1:0]   data_o;
  logic            gnt_i;

  modport slave (
    input  flush_i, rr_i, req_i, lock_i, data_i, gnt_i,
    output gnt_o, req_o, data_o
  );

  modport master (
    output flush_i, rr_i, req_i, lock_i, data_i, gnt_i,
    input  gnt_o, req_o, data_o
  );

endinterface

// File: rtl/generic_arbiter_fifo.sv
// DW x DEPTH synchronous output FIFO; DEPTH=0 degenerates to a wire-through
// whose empty/full track the upstream valid and downstream ready.
module generic_arbiter_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);

  if (DEPTH == 0) begin : g_bypass
    assign data_o  = data_i;
    assign empty_o = ~push_i;
    assign full_o  = ~pop_i;
  end else begin : g_fifo
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] w_wp_nxt;
    logic [PW-1:0] w_rp_nxt;

    assign w_wp_nxt = (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
    assign w_rp_nxt = (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else if (flush_i) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (push_i) begin
          r_mem[r_wp] <= data_i;
          r_wp        <= w_wp_nxt;
        end
        if (pop_i) r_rp <= w_rp_nxt;
        if (push_i && !pop_i)      r_cnt <= r_cnt + 1'b1;
        else if (!push_i && pop_i) r_cnt <= r_cnt - 1'b1;
      end
    end

    assign data_o  = r_mem[r_rp];
    assign full_o  = (r_cnt == CW'(DEPTH));
    assign empty_o = (r_cnt == '0);
  end

endmodule

// File: rtl/generic_arbiter.sv
// N-way round-robin arbiter with per-port lock, feeding one valid/ready stream
// through an optional output FIFO.
module generic_arbiter
  import generic_arbiter_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned EXT_RR = 0,
  parameter int unsigned LEAKY  = 0,
  parameter int unsigned DEPTH  = 2
) (
  input logic              clk_i,
  input logic              rst_ni,
  generic_arbiter_if.slave bus
);

  localparam int unsigned IW = idxw(N);
  localparam int unsigned SW = IW + 1;

  logic [IW-1:0] r_rr;
  lock_state_t   r_lock;

  logic [N-1:0]  w_own;
  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_rot;
  logic [IW-1:0] w_ptr;
  logic [IW-1:0] w_off;
  logic [SW-1:0] w_sum;
  logic [IW-1:0] w_sel;
  logic [IW-1:0] w_sel_nxt;
  logic [DW-1:0] w_sel_data;
  logic          w_own_req;
  logic          w_own_lock;
  logic          w_locked;
  logic          w_any;
  logic          w_acc;
  logic          w_hs;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;

  // Owner decode compares the full stored index so no lock-state bit is left dangling.
  always_comb begin
    w_own = '0;
    for (int unsigned k = 0; k < N; k++) w_own[k] = (r_lock.lidx_q == LIDX_MAXW'(k));
  end

  always_comb begin
    w_ptr      = (EXT_RR != 0) ? bus.rr_i : r_rr;
    w_own_req  = |(bus.req_i & w_own);
    w_own_lock = |(bus.lock_i & w_own);
    // Lock drops out combinationally in the cycle its owner deasserts lock_i.
    w_locked   = r_lock.lock_q & w_own_lock;
    if (!w_locked)       w_elig = bus.req_i;
    else if (w_own_req)  w_elig = bus.req_i & w_own;
    else if (LEAKY != 0) w_elig = bus.req_i;
    else                 w_elig = '0;
    w_any = |w_elig;

    w_rot = N'({w_elig, w_elig} >> w_ptr);
    w_off = '0;
    for (int unsigned i = N; i > 0; i--) if (w_rot[i-1]) w_off = IW'(i - 1);
    w_sum = {1'b0, w_off} + {1'b0, w_ptr};
    w_sel = (w_sum >= SW'(N)) ? IW'(w_sum - SW'(N)) : IW'(w_sum);

    w_sel_nxt  = (w_sel == IW'(N - 1)) ? '0 : w_sel + 1'b1;
    w_sel_data = bus.data_i[w_sel*DW +: DW];
  end

  assign w_pop     = ~w_empty & bus.gnt_i;
  assign w_acc     = ~w_full | w_pop;
  assign w_hs      = w_any & w_acc & ~bus.flush_i;
  assign w_push    = (DEPTH == 0) ? w_any : w_hs;
  assign bus.gnt_o = w_hs ? (N'(1) << w_sel) : '0;
  assign bus.req_o = ~w_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr   <= '0;
      r_lock <= '0;
    end else if (bus.flush_i) begin
      r_rr   <= '0;
      r_lock <= '0;
    end else begin
      if (r_lock.lock_q && !w_own_lock) r_lock.lock_q <= 1'b0;
      if (w_hs) begin
        if (bus.lock_i[w_sel]) begin
          r_rr          <= w_sel;
          r_lock.lock_q <= 1'b1;
          r_lock.lidx_q <= LIDX_MAXW'(w_sel);
        end else begin
          r_rr <= w_sel_nxt;
        end
      end
    end
  end

  generic_arbiter_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (bus.flush_i),
    .push_i  (w_push),
    .data_i  (w_sel_data),
    .pop_i   (w_pop),
    .data_o  (bus.data_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

endmodule

// File: tb/tb_generic_arbiter.sv
// Directed bench for generic_arbiter: baseline, leaky and external-pointer instances
// share one stimulus stream; the baseline output stream is checked via a scoreboard.
module tb_generic_arbiter;
  import generic_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [2:0]  rr;
  logic [7:0]  req;
  logic [7:0]  lock;
  logic        gi;
  logic [63:0] data;

  int checks;
  int failures;
  logic [7:0] sb[$];

  generic_arbiter_if #(.N(8), .DW(8)) ifm ();
  generic_arbiter_if #(.N(8), .DW(8)) ifl ();
  generic_arbiter_if #(.N(8), .DW(8)) ife ();

  assign ifm.flush_i = flush;
  assign ifm.rr_i    = rr;
  assign ifm.req_i   = req;
  assign ifm.lock_i  = lock;
  assign ifm.data_i  = data;
  assign ifm.gnt_i   = gi;
  assign ifl.flush_i = flush;
  assign ifl.rr_i    = rr;
  assign ifl.req_i   = req;
  assign ifl.lock_i  = lock;
  assign ifl.data_i  = data;
  assign ifl.gnt_i   = gi;
  assign ife.flush_i = flush;
  assign ife.rr_i    = rr;
  assign ife.req_i   = req;
  assign ife.lock_i  = lock;
  assign ife.data_i  = data;
  assign ife.gnt_i   = gi;

  generic_arbiter #(.N(8), .DW(8), .EXT_RR(0), .LEAKY(0), .DEPTH(2)) u_dut (
    .clk_i (clk), .rst_ni (rst_n), .bus (ifm)
  );
  generic_arbiter #(.N(8), .DW(8), .EXT_RR(0), .LEAKY(1), .DEPTH(2)) u_leaky (
    .clk_i (clk), .rst_ni (rst_n), .bus (ifl)
  );
  generic_arbiter #(.N(8), .DW(8), .EXT_RR(1), .LEAKY(0), .DEPTH(2)) u_ext (
    .clk_i (clk), .rst_ni (rst_n), .bus (ife)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Output-stream monitor: every beat accepted downstream must match the oldest expected datum.
  always @(negedge clk) begin
    if (rst_n && ifm.req_o && gi) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow act=%0h exp=none", ifm.data_o);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (ifm.data_o !== e) begin
          failures++;
          $display("FAIL sb_data act=%0h exp=%0h", ifm.data_o, e);
        end
      end
    end
  end

  // One clock: drive, check grants (and optional req_o / other instances) mid-cycle,
  // then queue the data the expected grant will deliver.
  task automatic cyc(input logic [7:0] r, input logic [7:0] l, input logic g,
                     input logic [7:0] e, input int ro, input int lk, input int ex,
                     input string nm);
    req  = r;
    lock = l;
    gi   = g;
    @(negedge clk);
    chk({nm, "_gnt"}, int'(ifm.gnt_o), int'(e));
    if (ro >= 0) chk({nm, "_req_o"}, int'(ifm.req_o), ro);
    if (lk >= 0) chk({nm, "_leaky_gnt"}, int'(ifl.gnt_o), lk);
    if (ex >= 0) chk({nm, "_ext_gnt"}, int'(ife.gnt_o), ex);
    @(posedge clk);
    for (int k = 0; k < 8; k++) if (e[k]) sb.push_back(8'(k + 1));
    #1;
  endtask

  task automatic flush_idle(input string nm);
    req   = 8'hff;
    lock  = 8'h00;
    gi    = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk({nm, "_flush_gnt"}, int'(ifm.gnt_o), 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb.delete();
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 0, -1, -1, {nm, "_idle"});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    data     = 64'h0807060504030201;
    rst_n    = 1'b0;
    flush    = 1'b0;
    rr       = 3'd0;
    req      = 8'h00;
    lock     = 8'h00;
    gi       = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",    int'(ifm.gnt_o),  0);
    chk("rst_req_o",  int'(ifm.req_o),  0);
    chk("rst_data_o", int'(ifm.data_o), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cyc(8'h01, 8'h00, 1'b1, 8'h01, 0, -1, -1, "first");
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 1, -1, -1, "first_out");

    flush_idle("rr");
    cyc(8'h05, 8'h00, 1'b1, 8'h01, -1, -1, -1, "rr05_a");
    cyc(8'h05, 8'h00, 1'b1, 8'h04, -1, -1, -1, "rr05_b");
    cyc(8'h05, 8'h00, 1'b1, 8'h01, -1, -1, -1, "rr05_c");
    cyc(8'h05, 8'h00, 1'b1, 8'h04, -1, -1, -1, "rr05_d");
    cyc(8'h30, 8'h00, 1'b1, 8'h10, -1, -1, -1, "rr30_a");
    cyc(8'h30, 8'h00, 1'b1, 8'h20, -1, -1, -1, "rr30_b");
    cyc(8'h30, 8'h00, 1'b1, 8'h10, -1, -1, -1, "rr30_c");
    cyc(8'h30, 8'h00, 1'b1, 8'h20, -1, -1, -1, "rr30_d");
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 1, -1, -1, "rr_drain");

    flush_idle("lock");
    cyc(8'hff, 8'h01, 1'b1, 8'h01, -1, -1, -1, "lock_a");
    cyc(8'hff, 8'h01, 1'b1, 8'h01, -1, -1, -1, "lock_b");
    cyc(8'hff, 8'h01, 1'b1, 8'h01, -1, -1, -1, "lock_c");
    cyc(8'hff, 8'h00, 1'b1, 8'h01, -1, -1, -1, "unlock_last");
    cyc(8'hff, 8'h00, 1'b1, 8'h02, -1, -1, -1, "unlock_p1");
    cyc(8'hff, 8'h00, 1'b1, 8'h04, -1, -1, -1, "unlock_p2");
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 1, -1, -1, "lock_drain");

    flush_idle("stall");
    cyc(8'h08, 8'h08, 1'b1, 8'h08, 0, 8'h08, -1, "stall_own");
    cyc(8'h03, 8'h08, 1'b1, 8'h00, 1, 8'h01, -1, "stall_a");
    cyc(8'h03, 8'h08, 1'b1, 8'h00, 0, 8'h02, -1, "stall_b");
    cyc(8'h03, 8'h00, 1'b1, 8'h01, 0, 8'h01, -1, "resume_a");
    cyc(8'h03, 8'h00, 1'b1, 8'h02, 1, 8'h02, -1, "resume_b");
    cyc(8'h03, 8'h00, 1'b1, 8'h01, -1, -1, -1, "resume_c");
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 1, -1, -1, "stall_drain");

    flush_idle("bp");
    cyc(8'hff, 8'h00, 1'b0, 8'h01, 0, -1, -1, "bp_g0");
    cyc(8'hff, 8'h00, 1'b0, 8'h02, 1, -1, -1, "bp_g1");
    cyc(8'hff, 8'h00, 1'b0, 8'h00, 1, -1, -1, "bp_full_a");
    cyc(8'hff, 8'h00, 1'b0, 8'h00, 1, -1, -1, "bp_full_b");
    cyc(8'hff, 8'h00, 1'b1, 8'h04, 1, -1, -1, "bp_full_pop_push");
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 1, -1, -1, "bp_drain_a");
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 1, -1, -1, "bp_drain_b");
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 0, -1, -1, "bp_empty");

    flush_idle("pre_fl");
    cyc(8'hff, 8'h00, 1'b0, 8'h01, 0, -1, -1, "fl_fill");
    flush_idle("fl");
    cyc(8'hff, 8'h00, 1'b1, 8'h01, 0, -1, -1, "fl_ptr0");
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 1, -1, -1, "fl_drain");

    rr = 3'd5;
    flush_idle("ext");
    cyc(8'hff, 8'h00, 1'b1, 8'h01, -1, -1, 8'h20, "ext_a");
    cyc(8'hff, 8'h00, 1'b1, 8'h02, -1, -1, 8'h20, "ext_b");
    cyc(8'hff, 8'h00, 1'b1, 8'h04, -1, -1, 8'h20, "ext_c");
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 1, -1, -1, "ext_drain");
    rr = 3'd0;

    flush_idle("arst");
    cyc(8'hff, 8'h00, 1'b0, 8'h01, 0, -1, -1, "arst_fill");
    req   = 8'h00;
    rst_n = 1'b0;
    #1;
    chk("arst_req_o",  int'(ifm.req_o),  0);
    chk("arst_data_o", int'(ifm.data_o), 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 0, -1, -1, "arst_after");
    cyc(8'h02, 8'h00, 1'b1, 8'h02, 0, -1, -1, "arst_regrant");
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 1, -1, -1, "arst_drain");
    cyc(8'h00, 8'h00, 1'b1, 8'h00, 0, -1, -1, "final_idle");
    chk("sb_leftover", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
